serial_divider: RTL and testbench

SERIAL_DIVIDER -- requirements
Module: serial_divider

---
 rtl/serial_divider.sv | 155 +++++++++++++++
 tb/tb_serial_divider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// Restoring unsigned divider: a 2*bits dividend divided by a bits-wide divisor,
// one quotient bit per clock, with ALU-style result flags.
module serial_divider #(
    parameter int bits = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*bits-1:0] dividend,
    input  logic [bits-1:0]   divisor,
    output logic              busy,
    output logic              done,
    output logic [bits-1:0]   q,
    output logic [bits-1:0]   r,
    output logic              c,
    output logic              z,
    output logic              v,
    output logic              n,
    output logic              dz
);

    localparam int CW = $clog2(bits + 1);

    typedef enum logic [1:0] {IDLE, RUN, EXC, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [bits-1:0] rem_q, rem_d;
    logic [bits-1:0] shf_q, shf_d;
    logic [bits-1:0] div_q, div_d;
    logic            zero_cause_q, zero_cause_d;
    logic [bits-1:0] q_q, q_d, r_q, r_d;
    logic            c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d, dz_q, dz_d;

    logic [bits:0]   shifted;
    logic            no_borrow;
    logic [bits-1:0] rem_next;
    logic [bits-1:0] quo_next;

    // shf_q starts as the low dividend half and fills with quotient bits as those shift out
    always_comb begin
        shifted   = {rem_q, shf_q[bits-1]};
        no_borrow = (shifted >= {1'b0, div_q});
        rem_next  = no_borrow ? (shifted[bits-1:0] - div_q) : shifted[bits-1:0];
        quo_next  = {shf_q[bits-2:0], no_borrow};
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rem_d        = rem_q;
        shf_d        = shf_q;
        div_d        = div_q;
        zero_cause_d = zero_cause_q;
        q_d          = q_q;
        r_d          = r_q;
        c_d          = c_q;
        z_d          = z_q;
        v_d          = v_q;
        n_d          = n_q;
        dz_d         = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d = divisor;
                    rem_d = dividend[2*bits-1:bits];
                    shf_d = dividend[bits-1:0];
                    if (divisor == '0) begin
                        zero_cause_d = 1'b1;
                        state_d      = EXC;
                    end else if (dividend[2*bits-1:bits] >= divisor) begin
                        zero_cause_d = 1'b0;
                        state_d      = EXC;
                    end else begin
                        count_d = CW'(bits);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d   = rem_next;
                shf_d   = quo_next;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = FIN;
                    q_d     = quo_next;
                    r_d     = rem_next;
                    n_d     = quo_next[bits-1];
                    z_d     = (quo_next == '0);
                    v_d     = 1'b0;
                    c_d     = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            EXC: begin
                state_d = FIN;
                dz_d    = zero_cause_q;
                v_d     = ~zero_cause_q;
                c_d     = 1'b0;
                n_d     = 1'b0;
                z_d     = 1'b0;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rem_q        <= '0;
            shf_q        <= '0;
            div_q        <= '0;
            zero_cause_q <= 1'b0;
            q_q          <= '0;
            r_q          <= '0;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            v_q          <= 1'b0;
            n_q          <= 1'b0;
            dz_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            shf_q        <= shf_d;
            div_q        <= div_d;
            zero_cause_q <= zero_cause_d;
            q_q          <= q_d;
            r_q          <= r_d;
            c_q          <= c_d;
            z_q          <= z_d;
            v_q          <= v_d;
            n_q          <= n_d;
            dz_q         <= dz_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == EXC);
    assign done = (state_q == FIN);
    assign q    = q_q;
    assign r    = r_q;
    assign c    = c_q;
    assign z    = z_q;
    assign v    = v_q;
    assign n    = n_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: issued requests push expected results
// from an arithmetic reference model; a monitor pops them on every DONE pulse.
module tb_serial_divider;

    localparam int BITS = 16;

    typedef struct {
        logic [BITS-1:0] q;
        logic [BITS-1:0] r;
        logic            n;
        logic            z;
        logic            v;
        logic            dz;
        int              edges;
        int              accept_cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2*BITS-1:0] dividend;
    logic [BITS-1:0]   divisor;
    logic              busy, done, c, z, v, n, dz;
    logic [BITS-1:0]   q, r;

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    exp_t            exp_q[$];
    logic [BITS-1:0] model_q = '0;
    logic [BITS-1:0] model_r = '0;

    serial_divider #(.bits(BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .c        (c),
        .z        (z),
        .v        (v),
        .n        (n),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    // Arithmetic reference: quotient that does not fit in BITS is an overflow
    task automatic issue(input logic [2*BITS-1:0] dd, input logic [BITS-1:0] ds);
        exp_t e;
        longint unsigned qq;
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = BITS'($urandom);
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
        e.accept_cyc = cyc;
        e.n = 1'b0;
        e.z = 1'b0;
        e.v = 1'b0;
        e.dz = 1'b0;
        e.q = model_q;
        e.r = model_r;
        e.edges = 2;
        if (ds == 0) begin
            e.dz = 1'b1;
        end else begin
            qq = longint'(dd) / longint'(ds);
            if (qq >= (64'd1 << BITS)) begin
                e.v = 1'b1;
            end else begin
                e.q = BITS'(qq);
                e.r = BITS'(longint'(dd) % longint'(ds));
                e.n = e.q[BITS-1];
                e.z = (e.q == 0);
                e.edges = BITS + 1;
            end
        end
        model_q = e.q;
        model_r = e.r;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2*BITS-1:0] dd, input logic [BITS-1:0] ds);
        waitIdle();
        issue(dd, ds);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("q", {16'd0, q}, {16'd0, e.q});
                checkOutput("r", {16'd0, r}, {16'd0, e.r});
                checkOutput("n", {31'd0, n}, {31'd0, e.n});
                checkOutput("z", {31'd0, z}, {31'd0, e.z});
                checkOutput("v", {31'd0, v}, {31'd0, e.v});
                checkOutput("dz", {31'd0, dz}, {31'd0, e.dz});
                checkOutput("c", {31'd0, c}, 32'd0);
                checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
                checkOutput("latency", 32'(cyc - e.accept_cyc + 1), 32'(e.edges));
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_q"}, {16'd0, q}, 32'd0);
        checkOutput({tag, "_r"}, {16'd0, r}, 32'd0);
        checkOutput({tag, "_flags"}, {27'd0, c, z, v, n, dz}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [BITS-1:0] ds, hi, lo;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");

        // START held during reset must not act until the first edge after release
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("start_in_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'd100, 16'd7);

        applyStimulus(32'h7FFF_8000, 16'hFFFF);
        applyStimulus(32'd100, 16'd7);
        applyStimulus(32'h0001_0000, 16'd1);
        applyStimulus(32'h0005_0000, 16'd0);

        applyStimulus(32'd0, 16'd5);
        repeat (4) @(negedge clk);
        dividend = 32'd1234;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;

        // Abort mid-RUN: no DONE, outputs cleared, model history cleared
        applyStimulus(32'd100, 16'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        exp_q.delete();
        model_q = '0;
        model_r = '0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'd100, 16'd7);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    ds = '0;
                    hi = BITS'($urandom);
                end
                1: begin
                    ds = BITS'($urandom_range(1, 65535));
                    hi = BITS'($urandom_range(int'(ds), 65535));
                end
                default: begin
                    ds = BITS'($urandom_range(1, 65535));
                    hi = BITS'($urandom % ds);
                end
            endcase
            lo = BITS'($urandom);
            applyStimulus({hi, lo}, ds);
        end

        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("hold_q", {16'd0, q}, {16'd0, model_q});
        checkOutput("hold_r", {16'd0, r}, {16'd0, model_r});
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
